mem_stage_ctrl: RTL and testbench

Sequencing controller for the MEM stage of the 5-stage RISC-V pipeline. It takes the load/store in EX/MEM and runs it against a variable-latency data memory using a req/ack handshake. While the access is outstanding it stalls the upstream stages and forces a bubble into MEM/WB. It hands the size-extended load data to MEM/WB on completion, and converts memory errors and timeouts into a fault pulse.

---
 rtl/mem_stage_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage load/store sequencer with req/ack data memory handshake
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_exmem_valid,
  input  logic        i_exmem_memread,
  input  logic        i_exmem_memwrite,
  input  logic [2:0]  i_exmem_funct3,
  input  logic [63:0] i_exmem_addr,
  input  logic [63:0] i_exmem_wdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [1:0]  o_dmem_size,
  output logic [63:0] o_dmem_addr,
  output logic [63:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic        i_dmem_err,
  input  logic [63:0] i_dmem_rdata,
  output logic [63:0] o_read_data,
  output logic        o_pipe_stall,
  output logic        o_memwb_bubble,
  output logic        o_mem_fault,
  output logic [63:0] o_fault_addr
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Last BUSY cycle before the access is abandoned as timed out.
  localparam logic [7:0] L_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic        r_req;
  logic        r_we;
  logic [1:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_read_data;
  logic        r_fault;
  logic [63:0] r_fault_addr;

  logic        w_access;
  logic        w_ack_ok;
  logic        w_fail;
  logic        w_stall;
  logic [63:0] w_ext;

  assign w_access = i_exmem_valid & (i_exmem_memread | i_exmem_memwrite);
  assign w_ack_ok = i_dmem_ack & ~i_dmem_err;
  // An ack on the last allowed cycle still completes normally; only a missing ack times out.
  assign w_fail   = (i_dmem_ack & i_dmem_err) | (~i_dmem_ack & (r_cnt == L_CNT_LAST));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and stall/bubble decode; stall is masked during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_stall     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_ack_ok || w_fail) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_reset) w_stall = 1'b0;
  end

  // Size/sign extension of the right-aligned read data, selected by the latched funct3.
  always_comb begin
    w_ext = i_dmem_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{56{i_dmem_rdata[7]}},  i_dmem_rdata[7:0]};
      3'b001:  w_ext = {{48{i_dmem_rdata[15]}}, i_dmem_rdata[15:0]};
      3'b010:  w_ext = {{32{i_dmem_rdata[31]}}, i_dmem_rdata[31:0]};
      3'b100:  w_ext = {56'd0, i_dmem_rdata[7:0]};
      3'b101:  w_ext = {48'd0, i_dmem_rdata[15:0]};
      3'b110:  w_ext = {32'd0, i_dmem_rdata[31:0]};
      default: w_ext = i_dmem_rdata;
    endcase
  end

  // Request launch, completion capture and fault reporting.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= 8'd0;
      r_funct3     <= 3'd0;
      r_is_load    <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= 64'd0;
      r_wdata      <= 64'd0;
      r_read_data  <= 64'd0;
      r_fault      <= 1'b0;
      r_fault_addr <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_addr    <= i_exmem_addr;
            r_wdata   <= i_exmem_wdata;
            r_size    <= i_exmem_funct3[1:0];
            r_funct3  <= i_exmem_funct3;
            r_is_load <= i_exmem_memread;
            r_we      <= ~i_exmem_memread;
            r_req     <= 1'b1;
            r_cnt     <= 8'd0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_ack_ok) begin
            if (r_is_load) r_read_data <= w_ext;
            r_req <= 1'b0;
          end else if (w_fail) begin
            r_read_data  <= 64'd0;
            r_fault      <= 1'b1;
            r_fault_addr <= r_addr;
            r_req        <= 1'b0;
          end
        end
        S_DONE:  r_fault <= 1'b0;
        default: r_fault <= 1'b0;
      endcase
    end
  end

  assign o_dmem_req     = r_req;
  assign o_dmem_we      = r_we;
  assign o_dmem_size    = r_size;
  assign o_dmem_addr    = r_addr;
  assign o_dmem_wdata   = r_wdata;
  assign o_read_data    = r_read_data;
  assign o_pipe_stall   = w_stall;
  assign o_memwb_bubble = w_stall;
  assign o_mem_fault    = r_fault;
  assign o_fault_addr   = r_fault_addr;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        exmem_valid, exmem_memread, exmem_memwrite;
  logic [2:0]  exmem_funct3;
  logic [63:0] exmem_addr, exmem_wdata;
  logic        dmem_req, dmem_we;
  logic [1:0]  dmem_size;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack, dmem_err;
  logic [63:0] dmem_rdata;
  logic [63:0] read_data;
  logic        pipe_stall, memwb_bubble, mem_fault;
  logic [63:0] fault_addr;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_exmem_valid(exmem_valid), .i_exmem_memread(exmem_memread),
    .i_exmem_memwrite(exmem_memwrite), .i_exmem_funct3(exmem_funct3),
    .i_exmem_addr(exmem_addr), .i_exmem_wdata(exmem_wdata),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_size(dmem_size),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ack(dmem_ack), .i_dmem_err(dmem_err), .i_dmem_rdata(dmem_rdata),
    .o_read_data(read_data), .o_pipe_stall(pipe_stall),
    .o_memwb_bubble(memwb_bubble), .o_mem_fault(mem_fault),
    .o_fault_addr(fault_addr)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [63:0] rd;
    logic [63:0] faddr;
    logic        fault;
    int          stalls;
    int          reqs;
    logic        we;
  } exp_t;

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          k;
    logic        err;
  } stim_t;

  exp_t        sb_q[$];
  logic [63:0] m_rd    = 64'd0;
  logic [63:0] m_faddr = 64'd0;

  // Request-gap monitor: dmem_req must be low at least 2 cycles between requests.
  int low_run  = 2;
  int gap_viol = 0;
  always @(negedge clk) begin
    if (reset) low_run = 2;
    else if (dmem_req) begin
      if (low_run > 0 && low_run < 2) gap_viol++;
      low_run = 0;
    end else low_run++;
  end

  function automatic logic [63:0] ext(input logic [2:0] f3, input logic [63:0] d);
    byte     sb;
    shortint sh;
    int      sw;
    sb = d[7:0];
    sh = d[15:0];
    sw = d[31:0];
    case (f3)
      3'd0:    ext = longint'(sb);
      3'd1:    ext = longint'(sh);
      3'd2:    ext = longint'(sw);
      3'd4:    ext = 64'(d[7:0]);
      3'd5:    ext = 64'(d[15:0]);
      3'd6:    ext = 64'(d[31:0]);
      default: ext = d;
    endcase
  endfunction

  task automatic push_exp(input stim_t s);
    exp_t e;
    logic tmo;
    logic flt;
    tmo = (s.k == 0) || (s.k > TO);
    flt = tmo || s.err;
    e.stalls = tmo ? TO + 1 : s.k + 1;
    e.reqs   = e.stalls - 1;
    e.we     = s.wr_en & ~s.rd_en;
    if (flt) begin
      m_rd    = 64'd0;
      m_faddr = s.addr;
    end else if (s.rd_en) m_rd = ext(s.f3, s.rdata);
    e.rd    = m_rd;
    e.faddr = m_faddr;
    e.fault = flt;
    sb_q.push_back(e);
  endtask

  // Drives one EX/MEM access from IDLE, acks at cycle k (0 = never) and returns what was observed.
  task automatic run_access(input stim_t s, output int stalls, output int bubbles, output int reqs,
                            output logic [63:0] rd_o, output logic [63:0] faddr_o,
                            output logic we_o, output int unstable, output int pulse);
    logic done;
    stalls = 0; bubbles = 0; reqs = 0; unstable = 0; pulse = 0;
    rd_o = 64'd0; faddr_o = 64'd0; we_o = 1'b0; done = 1'b0;
    exmem_valid = 1'b1; exmem_memread = s.rd_en; exmem_memwrite = s.wr_en;
    exmem_funct3 = s.f3; exmem_addr = s.addr; exmem_wdata = s.wdata;
    for (int c = 0; c < TO + 40; c++) begin
      dmem_ack   = (s.k > 0) && (c == s.k);
      dmem_err   = dmem_ack & s.err;
      dmem_rdata = dmem_ack ? s.rdata : ~s.rdata;
      @(negedge clk);
      if (pipe_stall) stalls++;
      if (memwb_bubble) bubbles++;
      if (mem_fault) pulse++;
      if (dmem_req) begin
        reqs++;
        we_o = dmem_we;
        if (dmem_addr !== s.addr || dmem_wdata !== s.wdata || dmem_size !== s.f3[1:0]) unstable++;
      end
      if (!pipe_stall && c > 0) begin
        rd_o = read_data; faddr_o = fault_addr; done = 1'b1;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    dmem_ack = 1'b0; dmem_err = 1'b0;
    exmem_valid = 1'b0; exmem_memread = 1'b0; exmem_memwrite = 1'b0;
    if (mem_fault) pulse++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    exmem_valid = 1'b1; exmem_memread = 1'b1; exmem_memwrite = 1'b0;
    exmem_funct3 = 3'd3; exmem_addr = 64'h40; exmem_wdata = 64'h55;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", pipe_stall); end
    n_total++; if (memwb_bubble !== 1'b0) begin n_bad++; $display("FAIL reset_bubble got=%b exp=0", memwb_bubble); end
    n_total++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    n_total++;
    if ({dmem_we, dmem_size, dmem_addr, dmem_wdata} !== 131'd0) begin
      n_bad++; $display("FAIL reset_dmem we=%b size=%0d addr=%h wdata=%h exp=all zero", dmem_we, dmem_size, dmem_addr, dmem_wdata);
    end
    n_total++;
    if ({read_data, mem_fault, fault_addr} !== 129'd0) begin
      n_bad++; $display("FAIL reset_out rd=%h fault=%b faddr=%h exp=all zero", read_data, mem_fault, fault_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0; exmem_valid = 1'b0; exmem_memread = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    stim_t t[$];
    exp_t e;
    int st, bb, rq, us, pl;
    logic [63:0] rd, fa;
    logic we;
    t.push_back('{1'b1, 1'b0, 3'd3, 64'h100, 64'h0, 64'h1122334455667788, 1, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd0, 64'h104, 64'h0, 64'h0123456789ABCD80, 3, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd4, 64'h104, 64'h0, 64'h0123456789ABCD80, 3, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd1, 64'h108, 64'h0, 64'h0000000000008001, 2, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd5, 64'h108, 64'h0, 64'h0000000000008001, 2, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd2, 64'h10C, 64'h0, 64'hFFFF000080000001, 1, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd6, 64'h10C, 64'h0, 64'hFFFF000080000001, 1, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd7, 64'h110, 64'h0, 64'hCAFEF00D12345678, 4, 1'b0});
    t.push_back('{1'b1, 1'b1, 3'd2, 64'h118, 64'h99, 64'h000000007FFFFFFF, 2, 1'b0});
    foreach (t[i]) begin
      push_exp(t[i]);
      run_access(t[i], st, bb, rq, rd, fa, we, us, pl);
      e = sb_q.pop_front();
      n_total++; if (rd !== e.rd) begin n_bad++; $display("FAIL load%0d_read_data got=%h exp=%h", i, rd, e.rd); end
      n_total++; if (st !== e.stalls) begin n_bad++; $display("FAIL load%0d_stalls got=%0d exp=%0d", i, st, e.stalls); end
      n_total++; if (bb !== e.stalls) begin n_bad++; $display("FAIL load%0d_bubbles got=%0d exp=%0d", i, bb, e.stalls); end
      n_total++; if (rq !== e.reqs) begin n_bad++; $display("FAIL load%0d_req_cycles got=%0d exp=%0d", i, rq, e.reqs); end
      n_total++; if (we !== e.we) begin n_bad++; $display("FAIL load%0d_we got=%b exp=%b", i, we, e.we); end
      n_total++; if (us !== 0) begin n_bad++; $display("FAIL load%0d_stable got=%0d bad cycles exp=0", i, us); end
      n_total++; if (pl !== 0) begin n_bad++; $display("FAIL load%0d_fault got=%0d cycles exp=0", i, pl); end
    end
  endtask

  task automatic test_store;
    stim_t t[$];
    exp_t e;
    int st, bb, rq, us, pl;
    logic [63:0] rd, fa;
    logic we;
    t.push_back('{1'b0, 1'b1, 3'd3, 64'h200, 64'h00000000DEADBEEF, 64'h5555AAAA5555AAAA, 2, 1'b0});
    t.push_back('{1'b0, 1'b1, 3'd0, 64'h207, 64'h00000000000000A5, 64'h1234, 1, 1'b0});
    foreach (t[i]) begin
      push_exp(t[i]);
      run_access(t[i], st, bb, rq, rd, fa, we, us, pl);
      e = sb_q.pop_front();
      n_total++; if (rd !== e.rd) begin n_bad++; $display("FAIL store%0d_read_data got=%h exp=%h", i, rd, e.rd); end
      n_total++; if (st !== e.stalls) begin n_bad++; $display("FAIL store%0d_stalls got=%0d exp=%0d", i, st, e.stalls); end
      n_total++; if (rq !== e.reqs) begin n_bad++; $display("FAIL store%0d_req_cycles got=%0d exp=%0d", i, rq, e.reqs); end
      n_total++; if (we !== e.we) begin n_bad++; $display("FAIL store%0d_we got=%b exp=%b", i, we, e.we); end
      n_total++; if (us !== 0) begin n_bad++; $display("FAIL store%0d_stable got=%0d bad cycles exp=0", i, us); end
    end
  endtask

  task automatic test_faults;
    stim_t t[$];
    exp_t e;
    int st, bb, rq, us, pl;
    logic [63:0] rd, fa;
    logic we;
    t.push_back('{1'b1, 1'b0, 3'd3, 64'h400, 64'h0, 64'h1111, 0, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd3, 64'h118, 64'h0, 64'hABCDEF0123456789, 3, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd3, 64'h500, 64'h0, 64'h2222, 2, 1'b1});
    t.push_back('{1'b0, 1'b1, 3'd2, 64'h600, 64'h77, 64'h3333, 1, 1'b1});
    t.push_back('{1'b1, 1'b0, 3'd3, 64'h700, 64'h0, 64'h0F0E0D0C0B0A0908, TO, 1'b0});
    foreach (t[i]) begin
      push_exp(t[i]);
      run_access(t[i], st, bb, rq, rd, fa, we, us, pl);
      e = sb_q.pop_front();
      n_total++; if (rd !== e.rd) begin n_bad++; $display("FAIL fault%0d_read_data got=%h exp=%h", i, rd, e.rd); end
      n_total++; if (fa !== e.faddr) begin n_bad++; $display("FAIL fault%0d_fault_addr got=%h exp=%h", i, fa, e.faddr); end
      n_total++; if (pl !== int'(e.fault)) begin n_bad++; $display("FAIL fault%0d_pulse got=%0d cycles exp=%0d", i, pl, e.fault); end
      n_total++; if (st !== e.stalls) begin n_bad++; $display("FAIL fault%0d_stalls got=%0d exp=%0d", i, st, e.stalls); end
      n_total++; if (rq !== e.reqs) begin n_bad++; $display("FAIL fault%0d_req_cycles got=%0d exp=%0d", i, rq, e.reqs); end
    end
  endtask

  task automatic test_reset_mid;
    stim_t s;
    exp_t e;
    int st, bb, rq, us, pl;
    logic [63:0] rd, fa;
    logic we;
    exmem_valid = 1'b1; exmem_memread = 1'b1; exmem_memwrite = 1'b0;
    exmem_funct3 = 3'd3; exmem_addr = 64'h300; exmem_wdata = 64'h0;
    @(negedge clk);
    n_total++; if (pipe_stall !== 1'b1) begin n_bad++; $display("FAIL rstmid_stall0 got=%b exp=1", pipe_stall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req1 got=%b exp=1", dmem_req); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (pipe_stall !== 1'b0 || memwb_bubble !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_forced stall=%b bubble=%b exp=0", pipe_stall, memwb_bubble);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_rd = 64'd0; m_faddr = 64'd0;
    exmem_valid = 1'b0; exmem_memread = 1'b0;
    dmem_ack = 1'b1; dmem_err = 1'b0; dmem_rdata = 64'h9999888877776666;
    @(negedge clk);
    n_total++;
    if ({dmem_req, dmem_we, dmem_addr, read_data, mem_fault, fault_addr} !== 195'd0) begin
      n_bad++; $display("FAIL rstmid_cleared req=%b we=%b addr=%h rd=%h fault=%b faddr=%h exp=all zero",
                        dmem_req, dmem_we, dmem_addr, read_data, mem_fault, fault_addr);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_total++;
    if (read_data !== 64'd0 || dmem_req !== 1'b0 || pipe_stall !== 1'b0 || mem_fault !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_late_ack rd=%h req=%b stall=%b fault=%b exp=0", read_data, dmem_req, pipe_stall, mem_fault);
    end
    @(posedge clk); #1;
    s = '{1'b1, 1'b0, 3'd2, 64'h304, 64'h0, 64'h00000000FFFFFFFE, 2, 1'b0};
    push_exp(s);
    run_access(s, st, bb, rq, rd, fa, we, us, pl);
    e = sb_q.pop_front();
    n_total++; if (rd !== e.rd) begin n_bad++; $display("FAIL rstmid_lw_read_data got=%h exp=%h", rd, e.rd); end
    n_total++; if (st !== e.stalls) begin n_bad++; $display("FAIL rstmid_lw_stalls got=%0d exp=%0d", st, e.stalls); end
  endtask

  task automatic test_back_to_back;
    stim_t t[$];
    exp_t e;
    int st, bb, rq, us, pl;
    logic [63:0] rd, fa;
    logic we;
    t.push_back('{1'b1, 1'b0, 3'd2, 64'h800, 64'h0, 64'h0000000012345678, 1, 1'b0});
    t.push_back('{1'b0, 1'b1, 3'd2, 64'h808, 64'hC0FFEE, 64'h0, 2, 1'b0});
    t.push_back('{1'b0, 1'b0, 3'd0, 64'h0, 64'h0, 64'h0, 0, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd1, 64'h810, 64'h0, 64'h000000000000F00F, 3, 1'b0});
    t.push_back('{1'b1, 1'b0, 3'd3, 64'h818, 64'h0, 64'h8877665544332211, 1, 1'b0});
    foreach (t[i]) begin
      if (!t[i].rd_en && !t[i].wr_en) begin
        exmem_valid = 1'b1; exmem_memread = 1'b0; exmem_memwrite = 1'b0;
        @(negedge clk);
        n_total++;
        if (pipe_stall !== 1'b0 || memwb_bubble !== 1'b0) begin
          n_bad++; $display("FAIL b2b_add_stall stall=%b bubble=%b exp=0", pipe_stall, memwb_bubble);
        end
        @(posedge clk); #1;
        n_total++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL b2b_add_req got=%b exp=0", dmem_req); end
        exmem_valid = 1'b0;
      end else begin
        push_exp(t[i]);
        run_access(t[i], st, bb, rq, rd, fa, we, us, pl);
        e = sb_q.pop_front();
        n_total++; if (rd !== e.rd) begin n_bad++; $display("FAIL b2b%0d_read_data got=%h exp=%h", i, rd, e.rd); end
        n_total++; if (st !== e.stalls) begin n_bad++; $display("FAIL b2b%0d_stalls got=%0d exp=%0d", i, st, e.stalls); end
        n_total++; if (rq !== e.reqs) begin n_bad++; $display("FAIL b2b%0d_req_cycles got=%0d exp=%0d", i, rq, e.reqs); end
      end
    end
    dmem_ack = 1'b1; dmem_err = 1'b1; dmem_rdata = 64'hDEAD;
    @(negedge clk);
    n_total++; if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL idle_ack_stall got=%b exp=0", pipe_stall); end
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_err = 1'b0;
    n_total++;
    if (read_data !== m_rd || mem_fault !== 1'b0 || dmem_req !== 1'b0 || fault_addr !== m_faddr) begin
      n_bad++; $display("FAIL idle_ack_ignored rd=%h fault=%b req=%b faddr=%h exp rd=%h fault=0 req=0 faddr=%h",
                        read_data, mem_fault, dmem_req, fault_addr, m_rd, m_faddr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    n_total++; if (gap_viol !== 0) begin n_bad++; $display("FAIL req_gap got=%0d short gaps exp=0", gap_viol); end
    n_total++; if (sb_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
